// File: rtl/operand_bank_writer.sv
// operand_bank_writer
//   Writer side of the A/B operand banks. Decodes framed write packets from a
//   byte stream (valid/ready) and issues single-cycle word writes.
//   Packet: header H {bank, burst, rsvd, addr[4:0]}, [count if burst],
//   then N words, each sent low byte then high byte. Count 0 means 32 words.
//   Optional feature (macro OPERAND_WRITER_CHECKSUM_EN): a trailing checksum
//   byte equal to the XOR of all preceding packet bytes; a mismatch pulses err.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_data    byte source
//   in_ready            byte accepted this cycle when in_valid is also high
//   wr_en/bank/addr/data  one-cycle write strobe and its payload (held between strobes)
//   busy                packet in progress
//   err                 one-cycle pulse on timeout or checksum failure
//   words_written       saturating count of write strobes since reset
module operand_bank_writer #(
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int ADDR_W         = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic              wr_bank,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   output logic              busy,
   output logic              err,
   output logic [15:0]       words_written
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef OPERAND_WRITER_CHECKSUM_EN
   typedef enum logic [2:0] {S_HDR, S_CNT, S_LO, S_HI, S_WR, S_CHK} state_t;
   localparam state_t S_END = S_CHK;
`else
   typedef enum logic [2:0] {S_HDR, S_CNT, S_LO, S_HI, S_WR} state_t;
   localparam state_t S_END = S_HDR;
`endif

   state_t            state, nxt;
   logic              bank;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        remaining;   // up to 255 words, or 32 when count is 0
   logic [7:0]        lo;
   logic [TW-1:0]     tcnt;
   logic              xfer;
   logic              timeout;
`ifdef OPERAND_WRITER_CHECKSUM_EN
   logic [7:0]        chk;
`endif

   assign in_ready = (state != S_WR);
   assign busy     = (state != S_HDR);
   assign xfer     = in_valid & in_ready;
   // Fires on the idle cycle that would take the counter to TIMEOUT_CYCLES.
   assign timeout  = busy & ~xfer & (tcnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= S_HDR;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      if (timeout) begin
         nxt = S_HDR;
      end else begin
         case (state)
            S_HDR: if (xfer) nxt = in_data[6] ? S_CNT : S_LO;
            S_CNT: if (xfer) nxt = S_LO;
            S_LO:  if (xfer) nxt = S_HI;
            S_HI:  if (xfer) nxt = S_WR;
            S_WR:  nxt = (remaining > 8'd1) ? S_LO : S_END;
`ifdef OPERAND_WRITER_CHECKSUM_EN
            S_CHK: if (xfer) nxt = S_HDR;
`endif
            default: nxt = S_HDR;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bank          <= 1'b0;
         addr          <= '0;
         remaining     <= '0;
         lo            <= '0;
         tcnt          <= '0;
         wr_en         <= 1'b0;
         wr_bank       <= 1'b0;
         wr_addr       <= '0;
         wr_data       <= '0;
         err           <= 1'b0;
         words_written <= '0;
`ifdef OPERAND_WRITER_CHECKSUM_EN
         chk           <= '0;
`endif
      end else begin
         wr_en <= 1'b0;
         err   <= timeout;

         if (state == S_HDR || xfer || timeout) tcnt <= '0;
         else                                   tcnt <= tcnt + TW'(1);

         if (wr_en && words_written != 16'hFFFF)
            words_written <= words_written + 16'd1;

`ifdef OPERAND_WRITER_CHECKSUM_EN
         if (xfer) chk <= (state == S_HDR) ? in_data : (chk ^ in_data);
`endif

         case (state)
            S_HDR: if (xfer) begin
               bank      <= in_data[7];
               addr      <= ADDR_W'(in_data[4:0]);
               remaining <= 8'd1;
            end
            S_CNT: if (xfer) remaining <= (in_data == 8'd0) ? 8'd32 : in_data;
            S_LO:  if (xfer) lo <= in_data;
            // Payload is registered here so the strobe appears the cycle after
            // the high byte and the wr_* values stay put until the next strobe.
            S_HI:  if (xfer) begin
               wr_en   <= 1'b1;
               wr_bank <= bank;
               wr_addr <= addr;
               wr_data <= {in_data, lo};
            end
            S_WR: begin
               addr      <= addr + ADDR_W'(1);
               remaining <= remaining - 8'd1;
            end
`ifdef OPERAND_WRITER_CHECKSUM_EN
            S_CHK: if (xfer && in_data != chk) err <= 1'b1;
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_operand_bank_writer.sv
module tb_operand_bank_writer;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready, wr_en, wr_bank, busy, err;
   logic [4:0]  wr_addr;
   logic [15:0] wr_data, words_written;

   operand_bank_writer #(.TIMEOUT_CYCLES(TO), .ADDR_W(5)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy(busy), .err(err), .words_written(words_written)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int ready_viol = 0, hold_viol = 0, err_cnt = 0;
   int exp_total = 0;
   logic [21:0] got[$], exp_q[$];   // {bank, addr, data}
   logic [21:0] last_w = '0;
   logic [15:0] dbuf[0:255];

   // Passive monitor: records strobes, counts err pulses, and notes any cycle
   // where in_ready is not simply the inverse of the write strobe or where the
   // write payload drifts between strobes.
   always @(negedge clk) begin
      if (err) err_cnt++;
      if (rst) last_w = '0;
      else begin
         if (in_ready !== !wr_en) ready_viol++;
         if (wr_en) begin
            got.push_back({wr_bank, wr_addr, wr_data});
            last_w = {wr_bank, wr_addr, wr_data};
         end else if ({wr_bank, wr_addr, wr_data} !== last_w) hold_viol++;
      end
   end

   task send_byte(input logic [7:0] b, input int gap);
      int n;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (n >= 100) begin
         failures++;
         $display("FAIL send_byte_stall: in_ready=%b required 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   function automatic int rgap(input int maxgap);
      return (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0));
   endfunction

   // Model: N words land at start, start+1, ... modulo 32, in order.
   task send_packet(input logic bank, input logic burst, input logic [4:0] start,
                    input logic [7:0] c, input int maxgap);
      int n;
      logic [7:0] h;
`ifdef OPERAND_WRITER_CHECKSUM_EN
      logic [7:0] x;
`endif
      n = burst ? ((c == 8'd0) ? 32 : int'(c)) : 1;
      h = {bank, burst, 1'b0, start};
      send_byte(h, rgap(maxgap));
      if (burst) send_byte(c, rgap(maxgap));
`ifdef OPERAND_WRITER_CHECKSUM_EN
      x = burst ? (h ^ c) : h;
`endif
      for (int i = 0; i < n; i++) begin
         send_byte(dbuf[i][7:0], rgap(maxgap));
         send_byte(dbuf[i][15:8], rgap(maxgap));
`ifdef OPERAND_WRITER_CHECKSUM_EN
         x = x ^ dbuf[i][7:0] ^ dbuf[i][15:8];
`endif
         exp_q.push_back({bank, 5'((int'(start) + i) % 32), dbuf[i]});
         exp_total++;
      end
`ifdef OPERAND_WRITER_CHECKSUM_EN
      send_byte(x, rgap(maxgap));
`endif
   endtask

   task check_writes(input string name);
      int m;
      repeat (4) @(negedge clk);
      checks++;
      if (got.size() != exp_q.size()) begin
         failures++;
         $display("FAIL %s_count: got %0d strobes, required %0d", name, got.size(), exp_q.size());
      end
      m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
      for (int i = 0; i < m; i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL %s_write%0d: got bank=%b addr=%0d data=%h, required bank=%b addr=%0d data=%h",
                     name, i, got[i][21], got[i][20:16], got[i][15:0],
                     exp_q[i][21], exp_q[i][20:16], exp_q[i][15:0]);
         end
      end
      checks++;
      if (words_written !== 16'(exp_total)) begin
         failures++;
         $display("FAIL %s_words_written: got %0d, required %0d", name, words_written, exp_total);
      end
      got.delete();
      exp_q.delete();
   endtask

   task check_idle_outputs(input string name);
      checks++;
      if ({in_ready, wr_en, busy, err, wr_bank, wr_addr, wr_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0}) begin
         failures++;
         $display("FAIL %s_outputs: got ready=%b en=%b busy=%b err=%b bank=%b addr=%0d data=%h, required 1 0 0 0 0 0 0000",
                  name, in_ready, wr_en, busy, err, wr_bank, wr_addr, wr_data);
      end
      checks++;
      if (words_written !== 16'd0) begin
         failures++;
         $display("FAIL %s_words_written: got %0d, required 0", name, words_written);
      end
   endtask

   task test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_idle_outputs("reset");
   endtask

   task test_single;
      dbuf[0] = 16'h1234;
      send_packet(1'b0, 1'b0, 5'd3, 8'd0, 0);
      check_writes("single");
   endtask

   task test_burst_b;
      dbuf[0] = 16'h0001; dbuf[1] = 16'hFFFF; dbuf[2] = 16'h8000;
      send_packet(1'b1, 1'b1, 5'd0, 8'd3, 0);
      check_writes("burst_b");
   endtask

   task test_wrap;
      for (int i = 0; i < 32; i++) dbuf[i] = 16'($urandom);
      send_packet(1'b0, 1'b1, 5'd30, 8'd0, 0);
      check_writes("wrap32");
   endtask

   task test_gaps;
      err_cnt = 0;
      for (int p = 0; p < 6; p++) begin
         for (int i = 0; i < 32; i++) dbuf[i] = 16'($urandom);
         send_packet(1'($urandom), 1'($urandom), 5'($urandom), 8'($urandom_range(8, 0)), 10);
         check_writes("gaps");
      end
      checks++;
      if (err_cnt != 0) begin
         failures++;
         $display("FAIL gaps_err: got %0d err pulses, required 0", err_cnt);
      end
   endtask

   task test_timeout;
      int first;
      err_cnt = 0;
      first = 0;
      dbuf[0] = 16'($urandom);
      send_byte(8'hC0, 0);
      send_byte(8'h02, 0);
      send_byte(dbuf[0][7:0], 0);
      send_byte(dbuf[0][15:8], 0);
      exp_q.push_back({1'b1, 5'd0, dbuf[0]});
      exp_total++;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (err && first == 0) first = i;
      end
      checks++;
      if (err_cnt != 1) begin
         failures++;
         $display("FAIL timeout_err_count: got %0d pulses, required 1", err_cnt);
      end
      checks++;
      if (first < 15 || first > 17) begin
         failures++;
         $display("FAIL timeout_err_cycle: got idle cycle %0d, required 16 (+/-1)", first);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL timeout_busy: got %b, required 0", busy);
      end
      check_writes("timeout");
      dbuf[0] = 16'h5AA5;
      send_packet(1'b1, 1'b0, 5'd7, 8'd0, 0);
      check_writes("after_timeout");
   endtask

   task test_reset_mid;
      send_byte(8'h03, 0);
      send_byte(8'h34, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_total = 0;
      repeat (3) @(negedge clk);
      checks++;
      if (got.size() != 0) begin
         failures++;
         $display("FAIL reset_mid_nowrite: got %0d strobes, required 0", got.size());
      end
      check_idle_outputs("reset_mid");
      got.delete();
      dbuf[0] = 16'hABCD;
      send_packet(1'b0, 1'b0, 5'd9, 8'd0, 0);
      check_writes("after_reset_mid");
   endtask

`ifdef OPERAND_WRITER_CHECKSUM_EN
   task test_checksum;
      logic [7:0] bad;
      err_cnt = 0;
      send_byte(8'h03, 0); send_byte(8'h34, 0); send_byte(8'h12, 0); send_byte(8'h25, 0);
      exp_q.push_back({1'b0, 5'd3, 16'h1234});
      exp_total++;
      check_writes("chk_good");
      checks++;
      if (err_cnt != 0) begin
         failures++;
         $display("FAIL chk_good_err: got %0d pulses, required 0", err_cnt);
      end
      bad = 8'h00;
      send_byte(8'h03, 0); send_byte(8'h34, 0); send_byte(8'h12, 0); send_byte(bad, 0);
      exp_q.push_back({1'b0, 5'd3, 16'h1234});
      exp_total++;
      check_writes("chk_bad");
      checks++;
      if (err_cnt != 1) begin
         failures++;
         $display("FAIL chk_bad_err: got %0d pulses, required 1", err_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_burst_b();
      test_wrap();
      test_gaps();
      test_timeout();
      test_reset_mid();
`ifdef OPERAND_WRITER_CHECKSUM_EN
      test_checksum();
`endif
      checks++;
      if (ready_viol != 0) begin
         failures++;
         $display("FAIL in_ready_vs_strobe: got %0d bad cycles, required 0", ready_viol);
      end
      checks++;
      if (hold_viol != 0) begin
         failures++;
         $display("FAIL wr_hold: got %0d drifting cycles, required 0", hold_viol);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/operand_bank_writer.md
Name: operand_bank_writer

Overview:
- Writer side of the 32x16 operand banks (bank A / bank B) that the ALU datapath reads by 5-bit address.
- Accepts a byte stream over a valid/ready handshake, decodes framed write packets and issues single-cycle word writes into the selected bank.
- Replaces the fixed preload pattern with host-loaded operands.

Parameters:
- TIMEOUT_CYCLES, 1000000, max idle cycles between bytes inside a packet before abort.
- ADDR_W, 5, bank address width (depth 2^ADDR_W).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  source has a byte
- in_data  input  8  byte value
- in_ready  output  1  writer accepts byte this cycle (transfer = in_valid & in_ready)
- wr_en  output  1  one-cycle write strobe
- wr_bank  output  1  0 = bank A, 1 = bank B
- wr_addr  output  ADDR_W  write address
- wr_data  output  16  write word
- busy  output  1  packet in progress (state != S_HDR)
- err  output  1  one-cycle pulse on timeout or checksum failure
- words_written  output  16  saturating count of wr_en pulses since reset

Behaviour:
- Reset (synchronous, active-high): state = S_HDR; in_ready=1; wr_en=0; wr_bank=0; wr_addr=0; wr_data=0; busy=0; err=0; words_written=0; timeout counter=0. rst mid-packet discards the partial packet; no write is issued.
- Packet format: header byte H, then [count byte if H[6]], then N words each sent low byte then high byte.
  - H[7] = bank, H[6] = burst, H[5] reserved (ignored), H[4:0] = start address.
  - Non-burst: N=1. Burst: count byte C, N = C if C != 0, N = 32 if C = 0.
- States:
  - S_HDR: wait for header; latch bank, burst, addr; go to S_CNT if burst, else S_LO with remaining=1.
  - S_CNT: latch N; go to S_LO.
  - S_LO: latch low byte; go to S_HI.
  - S_HI: latch high byte; go to S_WR.
  - S_WR:
    - in_ready=0.
    - Drive wr_en=1 for exactly one cycle with wr_bank, wr_addr, wr_data={hi,lo}.
    - Then addr <= addr+1 (wraps 31 -> 0) and remaining <= remaining-1.
    - Next state is S_LO if remaining was > 1; otherwise S_HDR (or S_CHK with the optional feature).
- Latency: wr_en asserts the cycle after the high-byte transfer; wr_* outputs hold their last value between strobes.
- in_ready = 1 in every state except S_WR; at most one byte is accepted per cycle.
- Timeout:
  - Counter clears on every accepted byte and in S_HDR; increments otherwise while busy.
  - When it reaches TIMEOUT_CYCLES, pulse err for 1 cycle and return to S_HDR.
  - Words already written in the burst remain written.
- words_written saturates at 16'hFFFF.
- A burst of 32 starting at address 5 wraps and ends at address 4; every address is written exactly once.
- Write collisions with the reader are the bank's concern; the writer does not stall on reads.

Optional Feature:
- Macro: OPERAND_WRITER_CHECKSUM_EN.
- Defined:
  - After the last word, state S_CHK expects one checksum byte equal to the XOR of all preceding packet bytes (header, count if present, data).
  - Mismatch: err pulses 1 cycle after the checksum transfer.
  - Writes are not rolled back.
  - Timeout also applies in S_CHK.
- Undefined: S_CHK does not exist; the packet ends after the last S_WR.

Test Plan:
- Reset then single write: bytes 8'h03, 8'h34, 8'h12 -> one wr_en cycle with wr_bank=0, wr_addr=3, wr_data=16'h1234, words_written=1.
- Burst to bank B: 8'hC0, 8'h03, then words 16'h0001, 16'hFFFF, 16'h8000 -> three strobes at addr 0, 1, 2 with bank=1 and matching data; in_ready=0 only during the S_WR cycles.
- Wrap and count=0: 8'h5E (bank A, burst, addr 30), count 8'h00, 32 words -> addresses 30, 31, 0 … 29; exactly 32 strobes.
- Backpressure/gaps: random in_valid gaps below TIMEOUT_CYCLES (set to 16) mid-packet -> identical writes, err never asserts.
- Timeout: header 8'hC0, count 2, one word, then 20 idle cycles with TIMEOUT_CYCLES=16 -> one write, err pulse at idle cycle 16, busy=0; the next header is decoded correctly.
- Reset mid-packet: rst asserted after the low byte -> no wr_en, all outputs at reset values; the following packet writes normally. With OPERAND_WRITER_CHECKSUM_EN: bytes 03 34 12 then checksum 8'h25 -> no err; checksum 8'h00 -> err pulse.
